// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads opcode (+ optional operand) bytes, issues them, then updates the PC.
// Latency: 1 FETCH cycle (+1 OPERAND cycle for two-byte opcodes) with mem_ack high, then ISSUE until ir_ack.
// Backpressure: mem_req/mem_addr are held until mem_ack arrives; ir_out/operand are held until ir_ack arrives.
// Optional build macro INSTR_FETCH_HALT_EN: opcode 0xFF halts fetch after it is acknowledged.
module instr_fetch #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [7:0]        ir_out,
  output logic [7:0]        operand,
  output logic              ir_valid,
  input  logic              ir_ack,
  input  logic              z_flag,
  input  logic              ge_flag,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);

  localparam logic [7:0] OP_JZ   = 8'hD0;
  localparam logic [7:0] OP_JGE  = 8'hD2;
  localparam logic [7:0] OP_JMP  = 8'hD4;
  localparam logic [7:0] OP_LOAD = 8'hD6;
`ifdef INSTR_FETCH_HALT_EN
  localparam logic [7:0] OP_HALT = 8'hFF;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_OPERAND = 3'd2,
`ifdef INSTR_FETCH_HALT_EN
    S_HALT    = 3'd4,
`endif
    S_ISSUE   = 3'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        operand_q, operand_d;

  logic              two_byte;
  logic              take_branch;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] branch_target;

  // Decode helpers: operand-carrying opcodes, branch decision, PC candidates.
  always_comb begin
    two_byte      = (mem_data == OP_JZ) || (mem_data == OP_JGE) ||
                    (mem_data == OP_JMP) || (mem_data == OP_LOAD);
    take_branch   = (ir_q == OP_JMP) ||
                    ((ir_q == OP_JZ) && z_flag) ||
                    ((ir_q == OP_JGE) && ge_flag);
    pc_inc        = pc_q + ADDR_W'(1);
    // Target is the operand zero-extended or truncated to the PC width.
    branch_target = ADDR_W'(operand_q);
  end

  // Next-state logic: memory handshake in FETCH/OPERAND, PC resolution on ir_ack in ISSUE.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    operand_d = operand_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          ir_d = mem_data;
          pc_d = pc_inc;
          if (two_byte) begin
            state_d = S_OPERAND;
          end else begin
            operand_d = 8'h00;
            state_d   = S_ISSUE;
          end
        end
      end
      S_OPERAND: begin
        if (mem_ack) begin
          operand_d = mem_data;
          pc_d      = pc_inc;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ir_ack) begin
          if (take_branch) begin
            pc_d = branch_target;
          end
          state_d = S_FETCH;
`ifdef INSTR_FETCH_HALT_EN
          if (ir_q == OP_HALT) begin
            state_d = S_HALT;
          end
`endif
        end
      end
`ifdef INSTR_FETCH_HALT_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= 8'h00;
      operand_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      operand_q <= operand_d;
    end
  end

  // Outputs decode directly from registered state, so mem_req and ir_valid are exclusive.
  always_comb begin
    mem_req  = (state_q == S_FETCH) || (state_q == S_OPERAND);
    mem_addr = pc_q;
    ir_valid = (state_q == S_ISSUE);
    ir_out   = ir_q;
    operand  = operand_q;
    pc_out   = pc_q;
`ifdef INSTR_FETCH_HALT_EN
    halted   = (state_q == S_HALT);
`else
    halted   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: program memory model answers mem_addr combinationally,
// inputs change and outputs are sampled on the falling clock edge.
module tb_instr_fetch;

  logic       clk;
  logic       rst;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic [7:0] ir_out;
  logic [7:0] operand;
  logic       ir_valid;
  logic       ir_ack;
  logic       z_flag;
  logic       ge_flag;
  logic [7:0] pc_out;
  logic       halted;

  logic [7:0] mem [0:255];
  int passed;
  int total;

  instr_fetch #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .ir_out(ir_out), .operand(operand), .ir_valid(ir_valid), .ir_ack(ir_ack),
    .z_flag(z_flag), .ge_flag(ge_flag), .pc_out(pc_out), .halted(halted)
  );

  assign mem_data = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Clears memory, resets, and returns at the falling edge of the first FETCH cycle.
  task automatic do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_ack = 1'b0; ir_ack = 1'b0; z_flag = 1'b0; ge_flag = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_ack = 1'b1; ir_ack = 1'b1; z_flag = 1'b0; ge_flag = 1'b0;
    rst = 1'b1;
    step(); step();
    total++; if ({mem_req, ir_valid, halted} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {mem_req, ir_valid, halted}); else passed++;
    total++; if (mem_addr !== 8'h00 || pc_out !== 8'h00) $display("FAIL reset_pc: got addr %h pc %h want 00 00", mem_addr, pc_out); else passed++;
    total++; if (ir_out !== 8'h00 || operand !== 8'h00) $display("FAIL reset_ir: got ir %h op %h want 00 00", ir_out, operand); else passed++;
    rst = 1'b0;
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) $display("FAIL reset_first_fetch: got req %b addr %h want 1 00", mem_req, mem_addr); else passed++;
    mem_ack = 1'b0; ir_ack = 1'b0;
  endtask

  task automatic test_sequential();
    do_reset();
    mem[0] = 8'h50; mem[1] = 8'h52;
    mem_ack = 1'b1; ir_ack = 1'b1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) $display("FAIL seq_addr0: got req %b addr %h want 1 00", mem_req, mem_addr); else passed++;
    step();
    total++; if (ir_valid !== 1'b1 || mem_req !== 1'b0 || ir_out !== 8'h50 || operand !== 8'h00)
      $display("FAIL seq_issue0: got v %b req %b ir %h op %h want 1 0 50 00", ir_valid, mem_req, ir_out, operand); else passed++;
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h01) $display("FAIL seq_addr1: got req %b addr %h want 1 01", mem_req, mem_addr); else passed++;
    step();
    total++; if (ir_valid !== 1'b1 || ir_out !== 8'h52 || operand !== 8'h00) $display("FAIL seq_issue1: got v %b ir %h op %h want 1 52 00", ir_valid, ir_out, operand); else passed++;
    step();
    total++; if (mem_addr !== 8'h02) $display("FAIL seq_addr2: got %h want 02", mem_addr); else passed++;
    mem_ack = 1'b0; ir_ack = 1'b0;
  endtask

  task automatic test_jump();
    do_reset();
    mem[0] = 8'hD4; mem[1] = 8'h10;
    mem_ack = 1'b1; ir_ack = 1'b1;
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h01 || ir_valid !== 1'b0 || ir_out !== 8'hD4)
      $display("FAIL jmp_operand_fetch: got req %b addr %h v %b ir %h want 1 01 0 d4", mem_req, mem_addr, ir_valid, ir_out); else passed++;
    step();
    total++; if (ir_valid !== 1'b1 || operand !== 8'h10 || ir_out !== 8'hD4) $display("FAIL jmp_issue: got v %b op %h ir %h want 1 10 d4", ir_valid, operand, ir_out); else passed++;
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h10) $display("FAIL jmp_target: got req %b addr %h want 1 10", mem_req, mem_addr); else passed++;
    mem_ack = 1'b0; ir_ack = 1'b0;
  endtask

  task automatic test_cond_branch(input logic [7:0] opc, input logic z, input logic ge, input logic [7:0] exp_addr);
    do_reset();
    mem[0] = opc; mem[1] = 8'h20;
    z_flag = z; ge_flag = ge;
    mem_ack = 1'b1; ir_ack = 1'b1;
    step(); step(); step();
    total++; if (mem_addr !== exp_addr || mem_req !== 1'b1)
      $display("FAIL cond_branch op %h z %b ge %b: got addr %h req %b want %h 1", opc, z, ge, mem_addr, mem_req, exp_addr); else passed++;
    mem_ack = 1'b0; ir_ack = 1'b0; z_flag = 1'b0; ge_flag = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    mem[0] = 8'h50;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || pc_out !== 8'h00 || ir_valid !== 1'b0)
        $display("FAIL stall_mem_%0d: got req %b addr %h pc %h v %b want 1 00 00 0", i, mem_req, mem_addr, pc_out, ir_valid); else passed++;
    end
    mem_ack = 1'b1;
    step();
    // Keep mem_ack high during ISSUE: it must be ignored there.
    for (int i = 0; i < 4; i++) begin
      total++; if (ir_valid !== 1'b1 || mem_req !== 1'b0 || ir_out !== 8'h50 || pc_out !== 8'h01)
        $display("FAIL stall_issue_%0d: got v %b req %b ir %h pc %h want 1 0 50 01", i, ir_valid, mem_req, ir_out, pc_out); else passed++;
      step();
    end
    mem_ack = 1'b0;
    ir_ack = 1'b1;
    step();
    ir_ack = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h01) $display("FAIL stall_resume: got req %b addr %h want 1 01", mem_req, mem_addr); else passed++;
    // ir_ack during FETCH is ignored: still waiting on memory at the same address.
    ir_ack = 1'b1;
    step();
    ir_ack = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h01 || ir_valid !== 1'b0) $display("FAIL stall_irack_ignored: got req %b addr %h v %b want 1 01 0", mem_req, mem_addr, ir_valid); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    mem[0] = 8'hD4; mem[1] = 8'hFF; mem[255] = 8'h50;
    mem_ack = 1'b1; ir_ack = 1'b1;
    step(); step(); step();
    total++; if (mem_addr !== 8'hFF) $display("FAIL wrap_at_ff: got %h want ff", mem_addr); else passed++;
    step();
    total++; if (ir_out !== 8'h50 || pc_out !== 8'h00) $display("FAIL wrap_issue: got ir %h pc %h want 50 00", ir_out, pc_out); else passed++;
    step();
    total++; if (mem_addr !== 8'h00 || mem_req !== 1'b1) $display("FAIL wrap_next: got addr %h req %b want 00 1", mem_addr, mem_req); else passed++;
    mem_ack = 1'b0; ir_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem[0] = 8'hD4; mem[1] = 8'h33;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h01 || ir_out !== 8'hD4) $display("FAIL mid_in_operand: got req %b addr %h ir %h want 1 01 d4", mem_req, mem_addr, ir_out); else passed++;
    rst = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0 || mem_addr !== 8'h00 || pc_out !== 8'h00 || ir_valid !== 1'b0 || ir_out !== 8'h00 || operand !== 8'h00 || halted !== 1'b0)
      $display("FAIL mid_async_reset: got req %b addr %h pc %h v %b ir %h op %h h %b want all zero", mem_req, mem_addr, pc_out, ir_valid, ir_out, operand, halted); else passed++;
    step();
    rst = 1'b0;
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) $display("FAIL mid_restart: got req %b addr %h want 1 00", mem_req, mem_addr); else passed++;
  endtask

  task automatic test_halt();
    do_reset();
    mem[0] = 8'hFF;
    mem_ack = 1'b1; ir_ack = 1'b1;
    step();
    total++; if (ir_valid !== 1'b1 || ir_out !== 8'hFF || operand !== 8'h00) $display("FAIL halt_issue: got v %b ir %h op %h want 1 ff 00", ir_valid, ir_out, operand); else passed++;
    step();
`ifdef INSTR_FETCH_HALT_EN
    for (int i = 0; i < 10; i++) begin
      total++; if (halted !== 1'b1 || mem_req !== 1'b0 || ir_valid !== 1'b0 || pc_out !== 8'h01)
        $display("FAIL halt_hold_%0d: got h %b req %b v %b pc %h want 1 0 0 01", i, halted, mem_req, ir_valid, pc_out); else passed++;
      step();
    end
`else
    total++; if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h01)
      $display("FAIL ff_not_halt: got h %b req %b addr %h want 0 1 01", halted, mem_req, mem_addr); else passed++;
`endif
    mem_ack = 1'b0; ir_ack = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1; mem_ack = 1'b0; ir_ack = 1'b0; z_flag = 1'b0; ge_flag = 1'b0;
    test_reset();
    test_sequential();
    test_jump();
    test_cond_branch(8'hD0, 1'b0, 1'b1, 8'h02);
    test_cond_branch(8'hD0, 1'b1, 1'b0, 8'h20);
    test_cond_branch(8'hD2, 1'b1, 1'b0, 8'h02);
    test_cond_branch(8'hD2, 1'b0, 1'b1, 8'h20);
    test_cond_branch(8'hD6, 1'b1, 1'b1, 8'h02);
    test_stall();
    test_wrap();
    test_reset_mid();
    test_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer for the 8-bit accumulator CPU: it reads opcode bytes and, for branch/load instructions, one operand byte from program memory. It presents the opcode on `ir_out` to the instruction decoder and holds it until the datapath acknowledges completion. It then updates the program counter, either sequentially or to a branch target chosen by the datapath flags. It sits between program memory and the decoder/control unit.

## Interface
- `ADDR_W`, default 8: program counter and memory address width.
- `clk` input 1: single system clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mem_req` output 1: read request to program memory.
- `mem_addr` output ADDR_W: read address, equal to the current PC while `mem_req` is high.
- `mem_ack` input 1: `mem_data` is valid this cycle; ignored when `mem_req` is low.
- `mem_data` input 8: read data.
- `ir_out` output 8: current opcode to the decoder.
- `operand` output 8: operand byte of a two-byte instruction; 0x00 for one-byte instructions.
- `ir_valid` output 1: `ir_out`/`operand` are valid for execution.
- `ir_ack` input 1: datapath finished the current instruction.
- `z_flag` input 1: zero flag from the ALU.
- `ge_flag` input 1: greater-or-equal flag from the ALU.
- `pc_out` output ADDR_W: current PC, for debug.
- `halted` output 1: fetch stopped (only with `INSTR_FETCH_HALT_EN`).

## Operation
- States: IDLE, FETCH, OPERAND, ISSUE, HALT.
- IDLE:
  - Entered on reset.
  - Moves to FETCH on the first clock after `rst` deasserts.
- FETCH:
  - Drives `mem_req`=1 and `mem_addr`=PC.
  - On `mem_ack`: latch `mem_data` into `ir_out` and set PC←PC+1.
  - Two-byte opcodes are 0xD0 (jz), 0xD2 (jge), 0xD4 (jmp) and 0xD6 (load); these go to OPERAND.
  - Any other opcode clears `operand` to 0x00 and goes to ISSUE.
- OPERAND:
  - Drives `mem_req`=1 and `mem_addr`=PC.
  - On `mem_ack`: latch `operand`, set PC←PC+1, go to ISSUE.
- ISSUE:
  - `ir_valid`=1; `ir_out` and `operand` are held stable.
  - On `ir_ack` the PC is resolved, then the state goes to FETCH.
  - jmp: PC←operand.
  - jz: PC←operand if `z_flag`=1.
  - jge: PC←operand if `ge_flag`=1.
  - Otherwise the PC keeps its sequential value.
  - Flags are sampled on the same edge as `ir_ack`.
  - The branch target is `operand` zero-extended or truncated to ADDR_W.
- PC arithmetic is modulo 2^ADDR_W: increment from all-ones wraps to 0.
- `mem_req` and `ir_valid` are never high in the same cycle.
- `ir_ack` outside ISSUE is ignored.
- `mem_ack` outside FETCH/OPERAND is ignored.

## Timing
- Reset values:
  - State IDLE, PC=0.
  - `ir_out`=0x00 (nop), `operand`=0x00.
  - `ir_valid`=0, `mem_req`=0, `mem_addr`=0, `halted`=0.
- `rst` asserted in any state, including mid-handshake, forces the reset values immediately and aborts the pending memory read.
- With `mem_ack` tied high, cycle counts are:
  - One-byte instruction: 1 FETCH cycle + ISSUE cycles until ack.
  - Two-byte instruction: 1 FETCH + 1 OPERAND + ISSUE.
- Minimum loop period is 2 cycles (one-byte instruction, `ir_ack` high on the first ISSUE cycle).
- `ir_valid` rises the cycle after the final `mem_ack`.
- The new PC is visible on `mem_addr` the cycle after `ir_ack`.
- `mem_ack` may be delayed arbitrarily; `mem_req` and `mem_addr` are held until it arrives.

## Configuration
- `INSTR_FETCH_HALT_EN` defined:
  - Opcode 0xFF is a one-byte halt.
  - It passes through ISSUE normally; on `ir_ack` the block enters HALT instead of FETCH.
  - In HALT: `halted`=1, `mem_req`=0, `ir_valid`=0, PC frozen.
  - Only `rst` leaves HALT.
- `INSTR_FETCH_HALT_EN` undefined:
  - The HALT state and its logic are absent; `halted` is tied to 0.
  - 0xFF is issued like any other one-byte opcode.

## Test plan
- Sequential fetch: memory 0x00:0x50, 0x01:0x52, `mem_ack` and `ir_ack` always high -> `ir_out` shows 0x50 then 0x52, `operand`=0x00, `mem_addr` sequence 0,1,2.
- Unconditional jump: 0x00:0xD4, 0x01:0x10 -> `operand`=0x10, and the next FETCH drives `mem_addr`=0x10.
- Conditional branches, program 0x00:0xD0, 0x01:0x20:
  - `z_flag`=0 at ack -> next fetch at 0x02.
  - `z_flag`=1 at ack -> next fetch at 0x20.
  - Repeat with 0xD2 and `ge_flag`.
- Stalls: `mem_ack` delayed 3 cycles and `ir_ack` delayed 4 cycles -> `mem_addr` stable throughout the wait, `ir_out` stable while `ir_valid`=1, no PC change.
- Wrap and reset:
  - PC at 0xFF with a one-byte opcode -> next `mem_addr`=0x00.
  - `rst` pulsed while in OPERAND -> all outputs return to reset values, and fetch restarts at address 0.
- With `INSTR_FETCH_HALT_EN`: 0x00:0xFF -> after `ir_ack`, `halted`=1 and `mem_req` stays 0 for 10 cycles; without the macro, fetch proceeds to 0x01.
